mem_arbiter: RTL and testbench

Shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch (IF) stage and data-memory (MEM) stage. Latches the granted request, holds it on the memory port until the memory acknowledges, then returns read data with a one-cycle done pulse. Raises per-side stall requests that the hazard unit ORs into stallF/stallD and the MEM-stage hold. Sits between the pipeline datapath and the memory model or bus bridge.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-side types and default widths for the pipeline, arbiter and memory model.
package mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

  function automatic logic is_busy(arb_state_t s);
    return s != IDLE;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the IF/MEM request ports and the unified memory port around the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_pkg::DATA_W
);

  logic              ireq;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] irdata;
  logic              idone;
  logic              istall;

  logic              dreq;
  logic              dwe;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dwdata;
  logic [DATA_W-1:0] drdata;
  logic              ddone;
  logic              dstall;

  logic              mreq;
  logic              mwe;
  logic [ADDR_W-1:0] maddr;
  logic [DATA_W-1:0] mwdata;
  logic [DATA_W-1:0] mrdata;
  logic              mready;

  // Arbiter view: serves the pipeline, masters the memory port.
  modport master (
    input  ireq, iaddr, dreq, dwe, daddr, dwdata, mrdata, mready,
    output irdata, idone, istall, drdata, ddone, dstall, mreq, mwe, maddr, mwdata
  );

  // Memory model / bus bridge view.
  modport slave (
    input  mreq, mwe, maddr, mwdata,
    output mrdata, mready
  );

  // Pipeline datapath view.
  modport pipe (
    output ireq, iaddr, dreq, dwe, daddr, dwdata,
    input  irdata, idone, istall, drdata, ddone, dstall
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and data access,
// data side first; holds the latched request until mready and pulses a done per side.
module mem_arbiter #(
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_pkg::DATA_W
) (
  input logic           clk,
  input logic           resetn,
  mem_arbiter_if.master bus
);
  import mem_pkg::*;

  arb_state_t        state_q, state_d;
  logic              grant_d, grant_i;

  logic              mreq_q;
  logic              mwe_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [DATA_W-1:0] mwdata_q;
  logic [DATA_W-1:0] irdata_q;
  logic [DATA_W-1:0] drdata_q;
  logic              idone_q;
  logic              ddone_q;

  // A side whose done is high still presents its completed request, so it is not re-granted.
  always_comb begin
    state_d = state_q;
    grant_d = 1'b0;
    grant_i = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.dreq && !ddone_q) begin
          grant_d = 1'b1;
          state_d = DBUSY;
        end else if (bus.ireq && !idone_q) begin
          grant_i = 1'b1;
          state_d = IBUSY;
        end
      end
      IBUSY, DBUSY: begin
        if (bus.mready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      idone_q  <= 1'b0;
      ddone_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idone_q <= 1'b0;
      ddone_q <= 1'b0;
      if (grant_d) begin
        mreq_q   <= 1'b1;
        mwe_q    <= bus.dwe;
        maddr_q  <= bus.daddr;
        mwdata_q <= bus.dwdata;
      end else if (grant_i) begin
        mreq_q  <= 1'b1;
        mwe_q   <= 1'b0;
        maddr_q <= bus.iaddr;
      end else if (is_busy(state_q) && bus.mready) begin
        mreq_q <= 1'b0;
        mwe_q  <= 1'b0;
        if (state_q == IBUSY) begin
          irdata_q <= bus.mrdata;
          idone_q  <= 1'b1;
        end else begin
          // Stores leave the previous load result in place.
          if (!mwe_q) begin
            drdata_q <= bus.mrdata;
          end
          ddone_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.istall = bus.ireq & ~idone_q;
    bus.dstall = bus.dreq & ~ddone_q;
  end

  assign bus.mreq   = mreq_q;
  assign bus.mwe    = mwe_q;
  assign bus.maddr  = maddr_q;
  assign bus.mwdata = mwdata_q;
  assign bus.irdata = irdata_q;
  assign bus.idone  = idone_q;
  assign bus.drdata = drdata_q;
  assign bus.ddone  = ddone_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle plus literal checks.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic resetn;
  logic run;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mreq_cyc = 0;
  int txn_cnt = 0;
  logic mreq_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    mreq_prev <= bus.mreq;
    if (bus.mreq) mreq_cyc <= mreq_cyc + 1;
    if (bus.mreq && !mreq_prev) txn_cnt <= txn_cnt + 1;
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk32(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Transaction model: one outstanding memory access at a time, data side wins,
  // a side is not re-served in its own done cycle.
  logic        m_busy, m_side_d, m_we;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  logic        m_idone, m_ddone;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy   <= 1'b0;
      m_side_d <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_irdata <= '0;
      m_drdata <= '0;
      m_idone  <= 1'b0;
      m_ddone  <= 1'b0;
    end else begin
      m_idone <= 1'b0;
      m_ddone <= 1'b0;
      if (m_busy) begin
        if (bus.mready) begin
          m_busy <= 1'b0;
          if (m_side_d) begin
            m_ddone <= 1'b1;
            if (!m_we) m_drdata <= bus.mrdata;
          end else begin
            m_idone  <= 1'b1;
            m_irdata <= bus.mrdata;
          end
        end
      end else if (bus.dreq && !m_ddone) begin
        m_busy   <= 1'b1;
        m_side_d <= 1'b1;
        m_we     <= bus.dwe;
        m_addr   <= bus.daddr;
        m_wdata  <= bus.dwdata;
      end else if (bus.ireq && !m_idone) begin
        m_busy   <= 1'b1;
        m_side_d <= 1'b0;
        m_we     <= 1'b0;
        m_addr   <= bus.iaddr;
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && run) begin
      chk1("mreq", bus.mreq, m_busy);
      if (m_busy) begin
        chk32("maddr", bus.maddr, m_addr);
        chk1("mwe", bus.mwe, m_we);
        if (m_we) chk32("mwdata", bus.mwdata, m_wdata);
      end
      chk1("idone", bus.idone, m_idone);
      chk1("ddone", bus.ddone, m_ddone);
      chk32("irdata", bus.irdata, m_irdata);
      chk32("drdata", bus.drdata, m_drdata);
      chk1("istall", bus.istall, bus.ireq & ~m_idone);
      chk1("dstall", bus.dstall, bus.dreq & ~m_ddone);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mreq();
    int g = 0;
    while (!bus.mreq && g < 20) begin
      step();
      g++;
    end
    chk1("mreq_timeout", bus.mreq, 1'b1);
  endtask

  task automatic serve(input int waits, input logic [31:0] rd);
    wait_mreq();
    repeat (waits) step();
    bus.mready = 1'b1;
    bus.mrdata = rd;
    step();
    bus.mready = 1'b0;
    bus.mrdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, m0, x0;
    run        = 1'b0;
    resetn     = 1'b1;
    bus.ireq   = 1'b0;
    bus.iaddr  = '0;
    bus.dreq   = 1'b0;
    bus.dwe    = 1'b0;
    bus.daddr  = '0;
    bus.dwdata = '0;
    bus.mrdata = '0;
    bus.mready = 1'b0;
    #1 resetn = 1'b0;
    #20;
    chk1("rst_mreq", bus.mreq, 1'b0);
    chk1("rst_mwe", bus.mwe, 1'b0);
    chk1("rst_idone", bus.idone, 1'b0);
    chk1("rst_ddone", bus.ddone, 1'b0);
    chk32("rst_maddr", bus.maddr, 32'h0);
    chk32("rst_mwdata", bus.mwdata, 32'h0);
    chk32("rst_irdata", bus.irdata, 32'h0);
    chk32("rst_drdata", bus.drdata, 32'h0);
    @(posedge clk);
    #1 resetn = 1'b1;
    run = 1'b1;
    step();

    // Single fetch, zero wait.
    x0 = txn_cnt;
    bus.ireq  = 1'b1;
    bus.iaddr = 32'h0040_0000;
    t0 = cyc;
    wait_mreq();
    chk32("t1_maddr", bus.maddr, 32'h0040_0000);
    chk1("t1_mwe", bus.mwe, 1'b0);
    chk1("t1_istall_busy", bus.istall, 1'b1);
    bus.mready = 1'b1;
    bus.mrdata = 32'h2008_0005;
    step();
    bus.mready = 1'b0;
    chk1("t1_idone", bus.idone, 1'b1);
    chk32("t1_irdata", bus.irdata, 32'h2008_0005);
    chk32("t1_latency", cyc - t0, 2);
    chk1("t1_istall_done", bus.istall, 1'b0);
    step();
    bus.ireq = 1'b0;
    chk1("t1_idone_pulse", bus.idone, 1'b0);
    chk32("t1_txn", txn_cnt - x0, 1);
    step();

    // Load with three wait cycles.
    m0 = mreq_cyc;
    bus.dreq  = 1'b1;
    bus.dwe   = 1'b0;
    bus.daddr = 32'h1001_0004;
    serve(3, 32'hDEAD_BEEF);
    chk32("t2_mreq_cycles", mreq_cyc - m0, 4);
    chk1("t2_ddone", bus.ddone, 1'b1);
    chk32("t2_drdata", bus.drdata, 32'hDEAD_BEEF);
    step();
    bus.dreq = 1'b0;
    step();

    // Collision: store served before the fetch.
    bus.ireq   = 1'b1;
    bus.iaddr  = 32'h0040_0004;
    bus.dreq   = 1'b1;
    bus.dwe    = 1'b1;
    bus.daddr  = 32'h1001_0000;
    bus.dwdata = 32'h1234_5678;
    wait_mreq();
    chk1("t3_mwe", bus.mwe, 1'b1);
    chk32("t3_maddr", bus.maddr, 32'h1001_0000);
    chk32("t3_mwdata", bus.mwdata, 32'h1234_5678);
    chk1("t3_istall", bus.istall, 1'b1);
    bus.mready = 1'b1;
    step();
    bus.mready = 1'b0;
    chk1("t3_ddone", bus.ddone, 1'b1);
    chk1("t3_no_idone", bus.idone, 1'b0);
    chk32("t3_drdata_kept", bus.drdata, 32'hDEAD_BEEF);
    chk1("t3_istall_ddone", bus.istall, 1'b1);
    step();
    bus.dreq = 1'b0;
    bus.dwe  = 1'b0;
    chk1("t3_fetch_mreq", bus.mreq, 1'b1);
    chk32("t3_fetch_maddr", bus.maddr, 32'h0040_0004);
    chk1("t3_fetch_mwe", bus.mwe, 1'b0);
    bus.mready = 1'b1;
    bus.mrdata = 32'h8C88_0000;
    step();
    bus.mready = 1'b0;
    chk1("t3_idone", bus.idone, 1'b1);
    chk32("t3_irdata", bus.irdata, 32'h8C88_0000);
    step();
    bus.ireq = 1'b0;
    step();

    // Fetch held through its done cycle is served once.
    x0 = txn_cnt;
    bus.ireq  = 1'b1;
    bus.iaddr = 32'h0040_0008;
    serve(2, 32'h0000_0013);
    chk1("t4_idone", bus.idone, 1'b1);
    step();
    bus.ireq = 1'b0;
    repeat (3) step();
    chk32("t4_single_txn", txn_cnt - x0, 1);

    // Input change while busy is ignored.
    bus.dreq  = 1'b1;
    bus.dwe   = 1'b0;
    bus.daddr = 32'h1001_0000;
    wait_mreq();
    step();
    bus.daddr = 32'h1001_0008;
    step();
    chk32("t5_maddr_held", bus.maddr, 32'h1001_0000);
    bus.mready = 1'b1;
    bus.mrdata = 32'hCAFE_F00D;
    step();
    bus.mready = 1'b0;
    chk1("t5_ddone", bus.ddone, 1'b1);
    chk32("t5_drdata", bus.drdata, 32'hCAFE_F00D);
    step();
    bus.dreq = 1'b0;
    step();

    // Asynchronous reset mid-transaction.
    bus.dreq   = 1'b1;
    bus.dwe    = 1'b1;
    bus.daddr  = 32'h1001_0010;
    bus.dwdata = 32'h55AA_55AA;
    wait_mreq();
    step();
    #2 resetn = 1'b0;
    #1;
    chk1("t6_rst_mreq", bus.mreq, 1'b0);
    chk1("t6_rst_mwe", bus.mwe, 1'b0);
    chk1("t6_rst_ddone", bus.ddone, 1'b0);
    chk32("t6_rst_maddr", bus.maddr, 32'h0);
    chk32("t6_rst_drdata", bus.drdata, 32'h0);
    chk1("t6_rst_dstall", bus.dstall, 1'b1);
    bus.dreq = 1'b0;
    bus.dwe  = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    step();
    bus.mready = 1'b1;
    bus.mrdata = 32'hFFFF_FFFF;
    step();
    bus.mready = 1'b0;
    chk1("t6_idle_mready_ddone", bus.ddone, 1'b0);
    chk1("t6_idle_mready_idone", bus.idone, 1'b0);
    chk1("t6_idle_mready_mreq", bus.mreq, 1'b0);
    step();
    chk1("t6_quiet_ddone", bus.ddone, 1'b0);
    chk32("t6_quiet_irdata", bus.irdata, 32'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
